// File: rtl/hpdmc_pkg.sv
// Shared types and constants for the HPDMC write-burst sequencer.
// FSM encoding, burst length and DQS drive patterns.
package hpdmc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DLY,
    ST_PRE,
    ST_B0,
    ST_B1,
    ST_POST
  } wr_state_e;

  localparam int BURST_CYC = 2;

  localparam logic DQS_IDLE = 1'b0;
  localparam logic DQS_RISE = 1'b1;
  localparam logic DQS_FALL = 1'b0;

  function automatic logic drives_dq(wr_state_e s);
    return (s == ST_B0) || (s == ST_B1);
  endfunction

  function automatic logic drives_dqs(wr_state_e s);
    return (s == ST_PRE) || (s == ST_B0) ||
           (s == ST_B1) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/hpdmc_wrburst_dly.sv
// Loadable 3-bit down-counter timing the pre-preamble delay.
// done_o is high while the count is zero.
module hpdmc_wrburst_dly (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [2:0] val_i,
  input  logic       en_i,
  output logic       done_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/hpdmc_wrburst.sv
// DDR write-burst sequencer: preamble, 2-cycle burst, postamble.
// Define HPDMC_WR_MASK_EN to register the DM outputs from wr_mask.
module hpdmc_wrburst
  import hpdmc_pkg::*;
#(
  parameter int DQ_WIDTH = 16,
  parameter int WR_DELAY = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    wr_start,
  output logic                    wr_ready,
  input  logic [2*DQ_WIDTH-1:0]   wr_data,
  input  logic [2*DQ_WIDTH/8-1:0] wr_mask,
  output logic                    wr_data_ack,
  output logic [DQ_WIDTH-1:0]     dq_d1,
  output logic [DQ_WIDTH-1:0]     dq_d2,
  output logic                    dq_oe,
  output logic [DQ_WIDTH/8-1:0]   dm_d1,
  output logic [DQ_WIDTH/8-1:0]   dm_d2,
  output logic [DQ_WIDTH/8-1:0]   dqs_d1,
  output logic [DQ_WIDTH/8-1:0]   dqs_d2,
  output logic                    dqs_oe,
  output logic                    busy
);

  localparam int NB = DQ_WIDTH / 8;
  localparam int BW = 2 * DQ_WIDTH;
  localparam bit B2B = (WR_DELAY == 0);

  wr_state_e state_q, state_d;
  logic      dly_done;

  logic          dq_oe_q, dq_oe_d;
  logic          dqs_oe_q, dqs_oe_d;
  logic [NB-1:0] dqs1_q, dqs2_q;
  logic [DQ_WIDTH-1:0] dq1_q, dq2_q;

  if (WR_DELAY > 0) begin : g_dly
    hpdmc_wrburst_dly u_dly (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .load_i (state_q == ST_IDLE && wr_start),
      .val_i  (3'(WR_DELAY - 1)),
      .en_i   (state_q == ST_DLY),
      .done_o (dly_done)
    );
  end else begin : g_nodly
    assign dly_done = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    wr_ready    = 1'b0;
    wr_data_ack = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_start) state_d = B2B ? ST_PRE : ST_DLY;
      end
      ST_DLY: begin
        if (dly_done) state_d = ST_PRE;
      end
      ST_PRE: begin
        wr_data_ack = 1'b1;
        state_d     = ST_B0;
      end
      ST_B0: begin
        wr_data_ack = 1'b1;
        state_d     = ST_B1;
      end
      ST_B1: begin
        state_d = ST_POST;
        // Chaining skips pre/postamble: next burst's first word now.
        if (B2B) begin
          wr_ready = 1'b1;
          if (wr_start) begin
            wr_data_ack = 1'b1;
            state_d     = ST_B0;
          end
        end
      end
      ST_POST: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!sys_rst_n) begin
      state_d     = ST_IDLE;
      wr_data_ack = 1'b0;
    end
  end

  assign dq_oe_d  = drives_dq(state_d);
  assign dqs_oe_d = drives_dqs(state_d);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs1_q   <= '0;
      dqs2_q   <= '0;
      dq1_q    <= '0;
      dq2_q    <= '0;
    end else begin
      state_q  <= state_d;
      dq_oe_q  <= dq_oe_d;
      dqs_oe_q <= dqs_oe_d;
      dqs1_q   <= {NB{dq_oe_d ? DQS_RISE : DQS_IDLE}};
      dqs2_q   <= {NB{dq_oe_d ? DQS_FALL : DQS_IDLE}};
      if (wr_data_ack) begin
        dq1_q <= wr_data[BW-1:DQ_WIDTH];
        dq2_q <= wr_data[DQ_WIDTH-1:0];
      end
    end
  end

`ifdef HPDMC_WR_MASK_EN
  logic [NB-1:0] dm1_q, dm2_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dm1_q <= '0;
      dm2_q <= '0;
    end else if (wr_data_ack) begin
      dm1_q <= wr_mask[2*NB-1:NB];
      dm2_q <= wr_mask[NB-1:0];
    end
  end

  assign dm_d1 = dm1_q;
  assign dm_d2 = dm2_q;
`else
  logic unused_mask;
  assign unused_mask = ^wr_mask;
  assign dm_d1 = '0;
  assign dm_d2 = '0;
`endif

  assign dq_d1  = dq1_q;
  assign dq_d2  = dq2_q;
  assign dq_oe  = dq_oe_q;
  assign dqs_d1 = dqs1_q;
  assign dqs_d2 = dqs2_q;
  assign dqs_oe = dqs_oe_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hpdmc_wrburst.sv
// Bench for hpdmc_wrburst: WR_DELAY=0 and WR_DELAY=3 instances
// against a cycle-plan reference model plus directed vectors.
module tb_hpdmc_wrburst;

`ifdef HPDMC_WR_MASK_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic st [2];
  logic rdy [2];
  logic [31:0] wd [2];
  logic [3:0] wm [2];
  logic ack [2];
  logic [15:0] dq1 [2];
  logic [15:0] dq2 [2];
  logic dqoe [2];
  logic [1:0] dm1 [2];
  logic [1:0] dm2 [2];
  logic [1:0] dqs1 [2];
  logic [1:0] dqs2 [2];
  logic dqsoe [2];
  logic bsy [2];

  hpdmc_wrburst #(.DQ_WIDTH(16), .WR_DELAY(0)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .wr_start(st[0]), .wr_ready(rdy[0]),
    .wr_data(wd[0]), .wr_mask(wm[0]), .wr_data_ack(ack[0]),
    .dq_d1(dq1[0]), .dq_d2(dq2[0]), .dq_oe(dqoe[0]),
    .dm_d1(dm1[0]), .dm_d2(dm2[0]),
    .dqs_d1(dqs1[0]), .dqs_d2(dqs2[0]), .dqs_oe(dqsoe[0]),
    .busy(bsy[0])
  );

  hpdmc_wrburst #(.DQ_WIDTH(16), .WR_DELAY(3)) dut3 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .wr_start(st[1]), .wr_ready(rdy[1]),
    .wr_data(wd[1]), .wr_mask(wm[1]), .wr_data_ack(ack[1]),
    .dq_d1(dq1[1]), .dq_d2(dq2[1]), .dq_oe(dqoe[1]),
    .dm_d1(dm1[1]), .dm_d2(dm2[1]),
    .dqs_d1(dqs1[1]), .dqs_d2(dqs2[1]), .dqs_oe(dqsoe[1]),
    .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench-side FIFO: head word, popped on every ack
  logic [31:0] mem [2][1024];
  logic [3:0] mmem [2][1024];
  int idx [2];

  assign wd[0] = mem[0][idx[0] & 1023];
  assign wm[0] = mmem[0][idx[0] & 1023];
  assign wd[1] = mem[1][idx[1] & 1023];
  assign wm[1] = mmem[1][idx[1] & 1023];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (ack[k] === 1'b1) idx[k] <= idx[k] + 1;
  end

  // reference plan: per cycle, whether a word is acked / on the pins
  bit eack [2][1024];
  bit edat [2][1024];
  int free_at [2];
  int last_b1 [2];
  int wl [2];
  int nack [2];
  int c;
  int total;
  int bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, c, act, exp);
    end
  endtask

  task automatic cyc_step(input bit s0, input bit s3, input bit rst);
    int d, a;
    bit rdy_e, busy_e, dat_e, dqs_e, acc;
    logic [31:0] w;
    logic [3:0] m;
    @(negedge clk);
    st[0] = s0;
    st[1] = s3;
    rst_n = !rst;
    #1;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 0 : 3;
      rdy_e = (c >= free_at[k]) || (d == 0 && c == last_b1[k]);
      busy_e = (c < free_at[k]);
      acc = ((k == 0) ? s0 : s3) && rdy_e && !rst;
      if (acc) begin
        a = (c >= free_at[k]) ? c + 1 + d : c;
        eack[k][a] = 1'b1;
        eack[k][a+1] = 1'b1;
        edat[k][a+1] = 1'b1;
        edat[k][a+2] = 1'b1;
        free_at[k] = a + 4;
        last_b1[k] = a + 2;
      end
      dat_e = edat[k][c];
      dqs_e = dat_e || edat[k][c+1] || (c > 0 && edat[k][c-1]);
      w = (wl[k] >= 0) ? mem[k][wl[k]] : 32'h0;
      m = (wl[k] >= 0 && MEN) ? mmem[k][wl[k]] : 4'h0;
      chk($sformatf("ready%0d", k), rdy[k], rdy_e);
      chk($sformatf("busy%0d", k), bsy[k], busy_e);
      chk($sformatf("ack%0d", k), ack[k], eack[k][c] && !rst);
      chk($sformatf("dq_oe%0d", k), dqoe[k], dat_e);
      chk($sformatf("dqs_oe%0d", k), dqsoe[k], dqs_e);
      chk($sformatf("dqs_d1_%0d", k), dqs1[k], dat_e ? 2'b11 : 2'b00);
      chk($sformatf("dqs_d2_%0d", k), dqs2[k], 2'b00);
      chk($sformatf("dq_d1_%0d", k), dq1[k], w[31:16]);
      chk($sformatf("dq_d2_%0d", k), dq2[k], w[15:0]);
      chk($sformatf("dm_d1_%0d", k), dm1[k], m[3:2]);
      chk($sformatf("dm_d2_%0d", k), dm2[k], m[1:0]);
      if (rst) begin
        for (int j = c; j < c + 9; j++) begin
          eack[k][j] = 1'b0;
          edat[k][j] = 1'b0;
        end
        free_at[k] = c + 1;
        last_b1[k] = -10;
        wl[k] = -1;
      end else if (eack[k][c]) begin
        wl[k] = nack[k];
        nack[k]++;
      end
    end
    c++;
  endtask

  typedef struct {
    bit st;
    bit ack;
    bit dqoe;
    bit dqsoe;
    bit rdy;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [1:0] m1;
    logic [1:0] m2;
  } vec_t;

  vec_t tbl [6];
  int n_ack, n_dq, n_dqs, n_nrdy;

  initial begin
    tbl[0] = '{1, 0, 0, 0, 1, 16'h0000, 16'h0000, 2'b00, 2'b00};
    tbl[1] = '{0, 1, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 2'b00};
    tbl[2] = '{0, 1, 1, 1, 0, 16'hAAAA, 16'h5555, 2'b10, 2'b01};
    tbl[3] = '{0, 0, 1, 1, 1, 16'h1234, 16'h8765, 2'b01, 2'b10};
    tbl[4] = '{0, 0, 0, 1, 0, 16'h1234, 16'h8765, 2'b01, 2'b10};
    tbl[5] = '{0, 0, 0, 0, 1, 16'h1234, 16'h8765, 2'b01, 2'b10};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) begin
        mem[k][i] = $urandom;
        mmem[k][i] = 4'($urandom_range(0, 15));
      end
      idx[k] = 0;
      free_at[k] = 0;
      last_b1[k] = -10;
      wl[k] = -1;
      nack[k] = 0;
    end
    mem[0][0] = 32'hAAAA5555;
    mmem[0][0] = 4'b1001;
    mem[0][1] = 32'h12348765;
    mmem[0][1] = 4'b0110;
    c = 0;
    total = 0;
    bad = 0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);

    // idle after reset
    repeat (10) cyc_step(0, 0, 0);

    // single burst, WR_DELAY=0
    for (int i = 0; i < 6; i++) begin
      cyc_step(tbl[i].st, 0, 0);
      chk("tbl_ack", ack[0], tbl[i].ack);
      chk("tbl_dq_oe", dqoe[0], tbl[i].dqoe);
      chk("tbl_dqs_oe", dqsoe[0], tbl[i].dqsoe);
      chk("tbl_ready", rdy[0], tbl[i].rdy);
      chk("tbl_dq_d1", dq1[0], tbl[i].d1);
      chk("tbl_dq_d2", dq2[0], tbl[i].d2);
      chk("tbl_dm_d1", dm1[0], MEN ? tbl[i].m1 : 2'b00);
      chk("tbl_dm_d2", dm2[0], MEN ? tbl[i].m2 : 2'b00);
    end

    // back-to-back: starts at relative cycles 0 and 3
    n_ack = 0; n_dq = 0; n_dqs = 0;
    for (int i = 0; i < 9; i++) begin
      cyc_step(i == 0 || i == 3, 0, 0);
      n_ack += int'(ack[0]);
      n_dq += int'(dqoe[0]);
      n_dqs += int'(dqsoe[0]);
    end
    chk("b2b_acks", n_ack, 4);
    chk("b2b_dq_oe_cycles", n_dq, 4);
    chk("b2b_dqs_oe_cycles", n_dqs, 6);

    // WR_DELAY=3, start held through B1 must not chain
    n_ack = 0; n_nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      cyc_step(0, i <= 6, 0);
      n_ack += int'(ack[1]);
      if (i >= 1 && i <= 7) n_nrdy += int'(!rdy[1]);
      if (i == 3) chk("dly_no_pre_yet", dqsoe[1], 1'b0);
      if (i == 4) chk("dly_pre", dqsoe[1], 1'b1);
      if (i == 5) chk("dly_first_data", dqoe[1], 1'b1);
    end
    chk("dly_acks", n_ack, 2);
    chk("dly_ready_low", n_nrdy, 7);

    // reset asserted while in B0
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      cyc_step(i == 0, 0, i == 2);
      n_ack += int'(ack[0]);
      if (i == 3) begin
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_oe", {dqoe[0], dqsoe[0]}, 2'b00);
      end
    end
    chk("rst_acks", n_ack, 1);

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      cyc_step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 59) == 0);
    end
    repeat (8) cyc_step(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
